// File: rtl/lsu_pipe_if.sv
// Request/response and board-I/O bundle for lsu_pipe; master = requester/board side, slave = lsu_pipe.
interface lsu_pipe_if #(
  parameter int ADDR_W  = 12,
  parameter int NUM_HEX = 8
);
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic                   req_we_i;
  logic [ADDR_W-1:0]      req_addr_i;
  logic [31:0]            req_wdata_i;
  logic [1:0]             req_size_i;
  logic                   req_unsigned_i;
  logic                   rsp_valid_o;
  logic [31:0]            rsp_rdata_o;
  logic                   rsp_err_o;
  logic [31:0]            io_button_i;
  logic [31:0]            io_sw_i;
  logic [NUM_HEX*32-1:0]  io_hex_o;
  logic [31:0]            io_ledr_o;
  logic [31:0]            io_ledg_o;
  logic [31:0]            io_lcd_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
    output io_button_i, io_sw_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    input  io_hex_o, io_ledr_o, io_ledg_o, io_lcd_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
    input  io_button_i, io_sw_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
    output io_hex_o, io_ledr_o, io_ledg_o, io_lcd_o
  );
endinterface

// File: rtl/lsu_pipe.sv
// Three-state load/store unit over data memory and memory-mapped board I/O.
// Define LSU_MISALIGN_TRAP_EN to report misaligned half/word accesses as errors instead of aligning them.
module lsu_pipe #(
  parameter int ADDR_W     = 12,
  parameter int DMEM_WORDS = 512,
  parameter int NUM_HEX    = 8
) (
  input logic       clk_i,
  input logic       rst_i,
  lsu_pipe_if.slave bus
);
  localparam int unsigned MEM_AW = $clog2(DMEM_WORDS);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;

  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [1:0]        size_q;
  logic              uns_q;

  logic [31:0] mem [DMEM_WORDS];
  logic [31:0] mem_rd;
  logic [31:0] hex [NUM_HEX];
  logic [31:0] ledr, ledg, lcd;
  logic [31:0] btn_s1, btn_s2, sw_s1, sw_s2;

  logic        rsp_valid, rsp_err, rd_ok, rd_mem;
  logic [31:0] io_rd;

  logic [ADDR_W-1:0] addr_eff;
  logic              err;
  logic              is_mem, is_out, is_in, mem_ok;
  logic [ADDR_W-4:0] idx;
  logic [3:0]        off;
  logic [3:0]        be;
  logic [31:0]       wd;
  logic [31:0]       io_word;
  logic              io_hit;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] en,
                                        input logic [31:0] val);
    logic [31:0] res;
    res = old;
    for (int unsigned b = 0; b < 4; b++)
      if (en[b]) res[8*b +: 8] = val[8*b +: 8];
    return res;
  endfunction

  // Decode works on the aligned address so the non-trapping build silently drops low bits.
  always_comb begin
    addr_eff = addr_q;
    if (size_q == 2'b01)      addr_eff[0]   = 1'b0;
    else if (size_q == 2'b10) addr_eff[1:0] = '0;
`ifdef LSU_MISALIGN_TRAP_EN
    err = (size_q == 2'b11) || (size_q == 2'b01 && addr_q[0]) ||
          (size_q == 2'b10 && addr_q[1:0] != 2'b00);
`else
    err = (size_q == 2'b11);
`endif
    is_mem = !addr_eff[ADDR_W-1];
    is_out = addr_eff[ADDR_W-1] && !addr_eff[8];
    is_in  = addr_eff[ADDR_W-1] && addr_eff[8];
    idx    = addr_eff[ADDR_W-2:2];
    mem_ok = 32'(idx) < 32'(DMEM_WORDS);
    off    = addr_eff[5:2];
    case (size_q)
      2'b00:   begin be = 4'b0001 << addr_eff[1:0]; wd = {4{wdata_q[7:0]}};  end
      2'b01:   begin be = addr_eff[1] ? 4'b1100 : 4'b0011; wd = {2{wdata_q[15:0]}}; end
      default: begin be = 4'b1111; wd = wdata_q; end
    endcase
  end

  always_comb begin
    io_word = '0;
    io_hit  = 1'b0;
    if (is_out) begin
      for (int unsigned n = 0; n < NUM_HEX; n++)
        if (off == 4'(n)) begin io_word = hex[n]; io_hit = 1'b1; end
      case (off)
        4'd8:    begin io_word = ledr; io_hit = 1'b1; end
        4'd9:    begin io_word = ledg; io_hit = 1'b1; end
        4'd10:   begin io_word = lcd;  io_hit = 1'b1; end
        default: ;
      endcase
    end else if (is_in) begin
      if (off == 4'd0)      begin io_word = btn_s2; io_hit = 1'b1; end
      else if (off == 4'd1) begin io_word = sw_s2;  io_hit = 1'b1; end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_ok     <= 1'b0;
      rd_mem    <= 1'b0;
      io_rd     <= '0;
      for (int unsigned n = 0; n < NUM_HEX; n++) hex[n] <= '0;
      ledr      <= '0;
      ledg      <= '0;
      lcd       <= '0;
      btn_s1    <= '0;
      btn_s2    <= '0;
      sw_s1     <= '0;
      sw_s2     <= '0;
    end else begin
      btn_s1    <= bus.io_button_i;
      btn_s2    <= btn_s1;
      sw_s1     <= bus.io_sw_i;
      sw_s2     <= sw_s1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rd_ok     <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid_i) begin
          we_q    <= bus.req_we_i;
          addr_q  <= bus.req_addr_i;
          wdata_q <= bus.req_wdata_i;
          size_q  <= bus.req_size_i;
          uns_q   <= bus.req_unsigned_i;
          state   <= ACCESS;
        end
        ACCESS: begin
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_err   <= err;
          rd_ok     <= !we_q && !err && (is_mem ? mem_ok : io_hit);
          rd_mem    <= is_mem;
          io_rd     <= io_word;
          if (we_q && !err && is_out) begin
            for (int unsigned n = 0; n < NUM_HEX; n++)
              if (off == 4'(n)) hex[n] <= merge(hex[n], be, wd);
            if (off == 4'd8)  ledr <= merge(ledr, be, wd);
            if (off == 4'd9)  ledg <= merge(ledg, be, wd);
            if (off == 4'd10) lcd  <= merge(lcd, be, wd);
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Reset forces the FSM out of ACCESS asynchronously, so an aborted store never reaches this write.
  always_ff @(posedge clk_i) begin
    if (state == ACCESS) begin
      mem_rd <= mem[idx[MEM_AW-1:0]];
      if (we_q && !err && is_mem && mem_ok)
        mem[idx[MEM_AW-1:0]] <= merge(mem[idx[MEM_AW-1:0]], be, wd);
    end
  end

  logic [31:0] src, shifted, ext;
  always_comb begin
    src     = rd_mem ? mem_rd : io_rd;
    shifted = src >> {addr_eff[1:0], 3'b000};
    case (size_q)
      2'b00:   ext = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   ext = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: ext = shifted;
    endcase
  end

  always_comb begin
    bus.io_hex_o = '0;
    for (int unsigned n = 0; n < NUM_HEX; n++) bus.io_hex_o[32*n +: 32] = hex[n];
  end

  assign bus.req_ready_o = (state == IDLE);
  assign bus.rsp_valid_o = rsp_valid;
  assign bus.rsp_err_o   = rsp_err;
  assign bus.rsp_rdata_o = rd_ok ? ext : '0;
  assign bus.io_ledr_o   = ledr;
  assign bus.io_ledg_o   = ledg;
  assign bus.io_lcd_o    = lcd;
endmodule

// File: tb/tb_lsu_pipe.sv
// Scoreboard bench for lsu_pipe: expected responses are queued at issue and checked on rsp_valid_o.
module tb_lsu_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lsu_pipe_if #(.ADDR_W(12), .NUM_HEX(8)) bus ();
  lsu_pipe #(.ADDR_W(12), .DMEM_WORDS(256), .NUM_HEX(8)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rsp_valid_o) begin
        if (sb.size() == 0) check_eq("unexpected_rsp", 64'(bus.rsp_valid_o), 64'd0);
        else begin
          mon_e = sb.pop_front();
          check_eq("rdata", 64'(bus.rsp_rdata_o), 64'(mon_e.rdata));
          check_eq("err", 64'(bus.rsp_err_o), 64'(mon_e.err));
          check_eq("latency", 64'(cyc - mon_e.acc), 64'd2);
        end
      end else begin
        check_eq("rsp_idle_zero", {31'b0, bus.rsp_err_o, bus.rsp_rdata_o}, 64'd0);
      end
    end
  end

  // Called at a negedge; returns just after the accepting posedge with req_valid_i still high.
  task automatic req(input logic we, input logic [11:0] a, input logic [31:0] wd,
                     input logic [1:0] sz, input logic u, input logic [31:0] er,
                     input logic ee, output int acc);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = we;
    bus.req_addr_i     = a;
    bus.req_wdata_i    = wd;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = u;
    for (int i = 0; i < 20 && !bus.req_ready_o; i++) @(negedge clk);
    acc = cyc;
    if (!bus.req_ready_o) check_eq("ready_timeout", 64'(bus.req_ready_o), 64'd1);
    else sb.push_back('{rdata: er, err: ee, acc: cyc});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) @(negedge clk);
    check_eq("drain", 64'(sb.size()), 64'd0);
    @(negedge clk);
  endtask

  task automatic op(input logic we, input logic [11:0] a, input logic [31:0] wd,
                    input logic [1:0] sz, input logic u, input logic [31:0] er, input logic ee);
    int acc;
    req(we, a, wd, sz, u, er, ee, acc);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    drain();
  endtask

  task automatic abort_store(input logic [11:0] a, input logic [31:0] wd);
    bus.req_valid_i    = 1'b1;
    bus.req_we_i       = 1'b1;
    bus.req_addr_i     = a;
    bus.req_wdata_i    = wd;
    bus.req_size_i     = 2'b10;
    bus.req_unsigned_i = 1'b0;
    check_eq("abort_ready", 64'(bus.req_ready_o), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid_i = 1'b0;
    #1;
    check_eq("abort_ready_in_rst", 64'(bus.req_ready_o), 64'd1);
    @(negedge clk);
    check_eq("abort_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_ready_after", 64'(bus.req_ready_o), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, a1, a2;
    rst = 1'b1;
    bus.req_valid_i = 1'b0; bus.req_we_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    bus.req_size_i = '0; bus.req_unsigned_i = 1'b0; bus.io_button_i = '0; bus.io_sw_i = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_ready", 64'(bus.req_ready_o), 64'd1);
    check_eq("rst_valid", 64'(bus.rsp_valid_o), 64'd0);
    check_eq("rst_hex0", 64'(bus.io_hex_o[31:0]), 64'd0);
    check_eq("rst_ledr", 64'(bus.io_ledr_o), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    op(1'b1, 12'h010, 32'hDEADBEEF, 2'b10, 1'b0, 32'h0, 1'b0);
    op(1'b0, 12'h010, 32'h0, 2'b10, 1'b0, 32'hDEADBEEF, 1'b0);
    op(1'b1, 12'h013, 32'h80, 2'b00, 1'b0, 32'h0, 1'b0);
    op(1'b0, 12'h013, 32'h0, 2'b00, 1'b0, 32'hFFFFFF80, 1'b0);
    op(1'b0, 12'h013, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b0);
    op(1'b0, 12'h010, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0);
    op(1'b0, 12'h012, 32'h0, 2'b01, 1'b0, 32'hFFFF80AD, 1'b0);

    op(1'b1, 12'h800, 32'h12345678, 2'b10, 1'b0, 32'h0, 1'b0);
    req(1'b1, 12'h822, 32'hABCD, 2'b01, 1'b0, 32'h0, 1'b0, a0);
    @(negedge clk);
    check_eq("ledr_in_access", 64'(bus.io_ledr_o), 64'd0);
    bus.req_valid_i = 1'b0;
    @(negedge clk);
    check_eq("ledr_in_resp", 64'(bus.io_ledr_o), 64'hABCD0000);
    drain();
    check_eq("hex0", 64'(bus.io_hex_o[31:0]), 64'h12345678);
    op(1'b0, 12'h800, 32'h0, 2'b10, 1'b0, 32'h12345678, 1'b0);
    op(1'b0, 12'h822, 32'h0, 2'b01, 1'b1, 32'h0000ABCD, 1'b0);
    op(1'b0, 12'h822, 32'h0, 2'b01, 1'b0, 32'hFFFFABCD, 1'b0);
    op(1'b0, 12'h823, 32'h0, 2'b00, 1'b0, 32'hFFFFFFAB, 1'b0);
    op(1'b0, 12'h830, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
    op(1'b0, 12'h908, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);

    op(1'b1, 12'h000, 32'h11111111, 2'b10, 1'b0, 32'h0, 1'b0);
    op(1'b1, 12'h400, 32'h22222222, 2'b10, 1'b0, 32'h0, 1'b0);
    op(1'b0, 12'h400, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
    op(1'b0, 12'h000, 32'h0, 2'b10, 1'b0, 32'h11111111, 1'b0);

    bus.io_sw_i = 32'h000000A5;
    op(1'b0, 12'h904, 32'h0, 2'b10, 1'b0, 32'h0, 1'b0);
    op(1'b0, 12'h904, 32'h0, 2'b10, 1'b0, 32'hA5, 1'b0);
    bus.io_sw_i = 32'h0000005A;
    repeat (2) @(negedge clk);
    op(1'b0, 12'h904, 32'h0, 2'b10, 1'b0, 32'h5A, 1'b0);
    bus.io_button_i = 32'h00000F0F;
    repeat (3) @(negedge clk);
    op(1'b0, 12'h900, 32'h0, 2'b10, 1'b0, 32'h00000F0F, 1'b0);
    op(1'b0, 12'h901, 32'h0, 2'b00, 1'b1, 32'h0000000F, 1'b0);
    op(1'b1, 12'h904, 32'hFFFFFFFF, 2'b10, 1'b0, 32'h0, 1'b0);
    check_eq("io_hex0_kept", 64'(bus.io_hex_o[31:0]), 64'h12345678);
    check_eq("io_ledr_kept", 64'(bus.io_ledr_o), 64'hABCD0000);
    check_eq("io_ledg_kept", 64'(bus.io_ledg_o), 64'd0);
    check_eq("io_lcd_kept", 64'(bus.io_lcd_o), 64'd0);
    op(1'b0, 12'h904, 32'h0, 2'b10, 1'b0, 32'h5A, 1'b0);

`ifdef LSU_MISALIGN_TRAP_EN
    op(1'b0, 12'h012, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
    op(1'b0, 12'h011, 32'h0, 2'b01, 1'b1, 32'h0, 1'b1);
`else
    op(1'b0, 12'h012, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0);
    op(1'b0, 12'h011, 32'h0, 2'b01, 1'b1, 32'h0000BEEF, 1'b0);
`endif
    op(1'b0, 12'h010, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
    op(1'b1, 12'h010, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
    op(1'b1, 12'h800, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
    check_eq("size3_hex0_kept", 64'(bus.io_hex_o[31:0]), 64'h12345678);
    op(1'b0, 12'h010, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0);

    abort_store(12'h800, 32'hCAFEF00D);
    check_eq("abort_hex0", 64'(bus.io_hex_o[31:0]), 64'd0);
    check_eq("abort_ledr", 64'(bus.io_ledr_o), 64'd0);
    abort_store(12'h010, 32'h0BADF00D);
    op(1'b0, 12'h010, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0);

    req(1'b0, 12'h000, 32'h0, 2'b10, 1'b0, 32'h11111111, 1'b0, a0);
    @(negedge clk);
    req(1'b0, 12'h010, 32'h0, 2'b10, 1'b0, 32'h80ADBEEF, 1'b0, a1);
    @(negedge clk);
    req(1'b0, 12'h013, 32'h0, 2'b00, 1'b1, 32'h00000080, 1'b0, a2);
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    drain();
    check_eq("b2b_gap1", 64'(a1 - a0), 64'd3);
    check_eq("b2b_gap2", 64'(a2 - a1), 64'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
